oclib_ready_valid_pipeline: RTL



---
 rtl/oclib_pkg.sv | 9 +
 rtl/oclib_ready_valid_skid_fifo.sv | 58 +++++
 rtl/oclib_ready_valid_pipeline.sv | 116 +++++++++++
 3 files changed

// File: rtl/oclib_pkg.sv
// Shared helpers for the oclib ready/valid pipeline and its skid FIFO.
package oclib_pkg;

  // Smallest skid FIFO that can absorb every beat still in flight once ready drops.
  function automatic int oclib_rv_pipeline_min_depth(input int length);
    return 2 * length + 2;
  endfunction

endpackage

// File: rtl/oclib_ready_valid_skid_fifo.sv
// Sink-side skid FIFO: registered storage, pointers wrap modulo Depth (any Depth >= 2).
// Simultaneous push and pop are both performed, including when full.
module oclib_ready_valid_skid_fifo #(
  parameter int Width = 1,
  parameter int Depth = 2
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         push,
  input  logic [Width-1:0]             pushData,
  input  logic                         pop,
  output logic [Width-1:0]             popData,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int CountW = $clog2(Depth + 1);
  localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0]  r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CountW-1:0] r_count;
  logic              w_full;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign w_full    = (r_count == CountW'(Depth));
  assign w_do_pop  = pop && (r_count != '0);
  // A push into a full FIFO is dropped unless a pop frees the slot in the same cycle.
  assign w_do_push = push && (!w_full || w_do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CountW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CountW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the count qualifies it, and a reset would block RAM mapping.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= pushData;
  end

  assign popData = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule

// File: rtl/oclib_ready_valid_pipeline.sv
// Retimed valid/ready stream: Length forward stages, Length-deep ready back-path, skid FIFO at the sink.
// Optional overflow checker enabled by defining OCLIB_READY_VALID_PIPELINE_CHECK_EN.
module oclib_ready_valid_pipeline
  import oclib_pkg::*;
#(
  parameter int Width     = 1,
  parameter int Length    = 0,
  parameter int SkidDepth = oclib_rv_pipeline_min_depth(Length),
  parameter bit DontTouch = 1'b0
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic [Width-1:0] inData,
  input  logic             inValid,
  output logic             inReady,
  output logic [Width-1:0] outData,
  output logic             outValid,
  input  logic             outReady,
  output logic             overflowError
);

  if (Length == 0) begin : g_wire
    logic w_unused_ok;
    assign w_unused_ok   = &{1'b0, clock, resetN, DontTouch};
    assign inReady       = outReady;
    assign outValid      = inValid;
    assign outData       = inData;
    assign overflowError = 1'b0;
  end else begin : g_pipe
    if (SkidDepth < oclib_rv_pipeline_min_depth(Length)) begin : g_bad_depth
      $error("SkidDepth %0d is below the minimum %0d for Length %0d",
             SkidDepth, oclib_rv_pipeline_min_depth(Length), Length);
    end

    localparam int CountW = $clog2(SkidDepth + 1);

    (* dont_touch = (DontTouch ? "true" : "false") *) logic [Width-1:0]  r_fwd_data [Length];
    (* dont_touch = (DontTouch ? "true" : "false") *) logic [Length-1:0] r_fwd_valid;
    // Bit 0 is readyLocal; bit Length-1 drives inReady.
    (* dont_touch = (DontTouch ? "true" : "false") *) logic [Length-1:0] r_ready_pipe;

    logic              w_push;
    logic              w_pop;
    logic [CountW-1:0] w_count;
    logic [Width-1:0]  w_pop_data;
    int                w_count_next;
    logic              w_ready_local_next;

    always_ff @(posedge clock) begin
      if (!resetN) begin
        r_fwd_valid  <= '0;
        r_ready_pipe <= '0;
      end else begin
        r_fwd_valid[0]  <= inValid && inReady;
        r_ready_pipe[0] <= w_ready_local_next;
        for (int i = 1; i < Length; i++) begin
          r_fwd_valid[i]  <= r_fwd_valid[i-1];
          r_ready_pipe[i] <= r_ready_pipe[i-1];
        end
      end
    end

    always_ff @(posedge clock) begin
      r_fwd_data[0] <= inData;
      for (int i = 1; i < Length; i++) r_fwd_data[i] <= r_fwd_data[i-1];
    end

    assign w_push       = r_fwd_valid[Length-1];
    assign w_pop        = outValid && outReady;
    assign w_count_next = int'(w_count) + int'(w_push) - int'(w_pop);
    // Leave room for every beat that can still arrive before a drop of readyLocal reaches inReady.
    assign w_ready_local_next = (w_count_next + 2 * Length + 1) <= SkidDepth;

    oclib_ready_valid_skid_fifo #(
      .Width (Width),
      .Depth (SkidDepth)
    ) u_fifo (
      .clock    (clock),
      .resetN   (resetN),
      .push     (w_push),
      .pushData (r_fwd_data[Length-1]),
      .pop      (w_pop),
      .popData  (w_pop_data),
      .count    (w_count)
    );

    assign inReady  = r_ready_pipe[Length-1];
    assign outValid = (w_count != '0);
    assign outData  = w_pop_data;

`ifdef OCLIB_READY_VALID_PIPELINE_CHECK_EN
    logic r_overflow;
    logic w_overflow_event;

    // Full with a simultaneous pop is a legal transfer, not an overflow.
    assign w_overflow_event = w_push && !w_pop && (w_count == CountW'(SkidDepth));

    always_ff @(posedge clock) begin
      if (!resetN) r_overflow <= 1'b0;
      else if (w_overflow_event) r_overflow <= 1'b1;
    end

    always_ff @(posedge clock) begin
      if (resetN) begin
        assert (!w_overflow_event)
          else $error("oclib_ready_valid_pipeline: push into full skid FIFO, beat dropped");
      end
    end

    assign overflowError = r_overflow;
`else
    assign overflowError = 1'b0;
`endif
  end

endmodule
